// File: rtl/pc_stack.sv
// LITE-16 program counter with relative/absolute branches, fetch stall
// and a hardware call/return stack with sticky overflow/underflow flags.
module pc_stack #(
    parameter int               WIDTH        = 16,
    parameter int               STACK_DEPTH  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    localparam int              SPW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             jmp,
    input  logic             cmp,
    input  logic             jmp_abs,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_next,
    output logic [SPW-1:0]   sp,
    output logic             stack_ovf,
    output logic             stack_unf
);

    localparam int             AW      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SPW-1:0] DEPTH_V = SPW'(STACK_DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [SPW-1:0]   r_sp;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] r_stack [2**AW];

    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dest;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_next;
    logic [AW-1:0]    w_push_idx;
    logic [AW-1:0]    w_top_idx;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_inc      = r_pc + 1'b1;
    assign w_dest     = jmp_abs ? target : r_pc + target;
    assign w_empty    = (r_sp == '0);
    assign w_full     = (r_sp == DEPTH_V);
    assign w_push_idx = AW'(r_sp);
    assign w_top_idx  = AW'(r_sp - 1'b1);
    assign w_top      = r_stack[w_top_idx];

    // Priority: rst > stall > ret > call > taken branch > increment
    always_comb begin
        w_next    = w_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (rst) begin
            w_next = RESET_VECTOR;
        end else if (stall) begin
            w_next = r_pc;
        end else if (ret) begin
            if (w_empty) begin
                w_unf_set = 1'b1;
            end else begin
                w_pop  = 1'b1;
                w_next = w_top;
            end
        end else if (call) begin
            w_next = w_dest;
            if (w_full) begin
                w_ovf_set = 1'b1;
            end else begin
                w_push = 1'b1;
            end
        end else if (jmp && cmp) begin
            w_next = w_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= RESET_VECTOR;
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc  <= w_next;
            r_ovf <= r_ovf | w_ovf_set;
            r_unf <= r_unf | w_unf_set;
            if (w_push) begin
                r_sp <= r_sp + 1'b1;
            end else if (w_pop) begin
                r_sp <= r_sp - 1'b1;
            end
        end
    end

    // Contents need no reset; only entries below sp are ever read
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_stack[w_push_idx] <= w_inc;
        end
    end

    assign pc_out    = r_pc;
    assign pc_next   = w_next;
    assign sp        = r_sp;
    assign stack_ovf = r_ovf;
    assign stack_unf = r_unf;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed scenarios plus randomized
// traffic against a queue-based behavioural model.
module tb_pc_stack;

    localparam int          W     = 16;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RV    = 16'h0010;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0;
    logic          jmp = 1'b0;
    logic          cmp = 1'b0;
    logic          jmp_abs = 1'b0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic [W-1:0]  target = '0;
    logic [W-1:0]  pc_out;
    logic [W-1:0]  pc_next;
    logic [2:0]    sp;
    logic          stack_ovf;
    logic          stack_unf;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pc;
    logic [15:0] m_stack [$];
    logic        m_ovf;
    logic        m_unf;

    pc_stack #(
        .WIDTH(W),
        .STACK_DEPTH(DEPTH),
        .RESET_VECTOR(RV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .jmp(jmp),
        .cmp(cmp),
        .jmp_abs(jmp_abs),
        .call(call),
        .ret(ret),
        .target(target),
        .pc_out(pc_out),
        .pc_next(pc_next),
        .sp(sp),
        .stack_ovf(stack_ovf),
        .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] m_dest();
        return jmp_abs ? target : 16'(m_pc + target);
    endfunction

    function automatic logic [15:0] exp_next();
        if (rst) return RV;
        if (stall) return m_pc;
        if (ret) return (m_stack.size() > 0) ? m_stack[$] : 16'(m_pc + 1);
        if (call || (jmp && cmp)) return m_dest();
        return 16'(m_pc + 1);
    endfunction

    task automatic m_apply();
        logic [15:0] nxt;
        nxt = exp_next();
        if (rst) begin
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!stall) begin
            if (ret) begin
                if (m_stack.size() > 0) void'(m_stack.pop_back());
                else m_unf = 1'b1;
            end else if (call) begin
                if (m_stack.size() < DEPTH) m_stack.push_back(16'(m_pc + 1));
                else m_ovf = 1'b1;
            end
        end
        m_pc = nxt;
    endtask

    task automatic set_in(input bit r, s, j, c, a, ca, re,
                          input logic [15:0] t);
        rst = r; stall = s; jmp = j; cmp = c;
        jmp_abs = a; call = ca; ret = re; target = t;
    endtask

    task automatic tick();
        @(posedge clk);
        m_apply();
        #1;
        set_in(0, 0, 0, 0, 0, 0, 0, 16'h0);
    endtask

    task automatic goto_pc(input logic [15:0] a);
        set_in(0, 0, 1, 1, 1, 0, 0, a);
        tick();
    endtask

    task automatic test_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 16'h0);
        tick();
        checks++;
        if (pc_out !== 16'h0010 || sp !== 3'd0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
            errors++;
            $display("FAIL reset: pc=%h sp=%0d ovf=%b unf=%b, required pc=0010 sp=0 flags 0",
                     pc_out, sp, stack_ovf, stack_unf);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (pc_out !== 16'(16'h0010 + i) || sp !== 3'd0 || stack_ovf || stack_unf) begin
                errors++;
                $display("FAIL incr%0d: pc=%h sp=%0d, required pc=%h sp=0", i, pc_out, sp,
                         16'(16'h0010 + i));
            end
        end
    endtask

    task automatic test_branches();
        goto_pc(16'h0020);
        set_in(0, 0, 1, 1, 0, 0, 0, 16'hFFFC);
        tick();
        checks++;
        if (pc_out !== 16'h001C) begin
            errors++;
            $display("FAIL br_rel: pc=%h, required 001C", pc_out);
        end
        goto_pc(16'h0020);
        set_in(0, 0, 1, 0, 0, 0, 0, 16'hFFFC);
        tick();
        checks++;
        if (pc_out !== 16'h0021) begin
            errors++;
            $display("FAIL br_not_taken: pc=%h, required 0021", pc_out);
        end
        set_in(0, 0, 1, 1, 1, 0, 0, 16'h0100);
        tick();
        checks++;
        if (pc_out !== 16'h0100) begin
            errors++;
            $display("FAIL br_abs: pc=%h, required 0100", pc_out);
        end
        goto_pc(16'hFFFF);
        tick();
        checks++;
        if (pc_out !== 16'h0000) begin
            errors++;
            $display("FAIL wrap: pc=%h, required 0000", pc_out);
        end
    endtask

    task automatic test_call_ret();
        goto_pc(16'h0040);
        set_in(0, 0, 0, 0, 1, 1, 0, 16'h0200);
        tick();
        checks++;
        if (pc_out !== 16'h0200 || sp !== 3'd1) begin
            errors++;
            $display("FAIL call: pc=%h sp=%0d, required pc=0200 sp=1", pc_out, sp);
        end
        tick();
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 16'h0);
        tick();
        checks++;
        if (pc_out !== 16'h0041 || sp !== 3'd0) begin
            errors++;
            $display("FAIL ret: pc=%h sp=%0d, required pc=0041 sp=0", pc_out, sp);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_ret [4];
        exp_ret = '{16'h0301, 16'h0301, 16'h0301, 16'h0002};
        goto_pc(16'h0001);
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 0, 0, 1, 1, 0, 16'h0300);
            tick();
        end
        checks++;
        if (pc_out !== 16'h0300 || sp !== 3'd4 || stack_ovf !== 1'b1 || stack_unf !== 1'b0) begin
            errors++;
            $display("FAIL ovf: pc=%h sp=%0d ovf=%b unf=%b, required pc=0300 sp=4 ovf=1 unf=0",
                     pc_out, sp, stack_ovf, stack_unf);
        end
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 16'h0);
            tick();
            checks++;
            if (pc_out !== exp_ret[i] || sp !== 3'(3 - i)) begin
                errors++;
                $display("FAIL pop%0d: pc=%h sp=%0d, required pc=%h sp=%0d",
                         i, pc_out, sp, exp_ret[i], 3 - i);
            end
        end
    endtask

    task automatic test_underflow_collision();
        logic [15:0] ra;
        goto_pc(16'h0050);
        set_in(0, 0, 0, 0, 0, 0, 1, 16'h0);
        tick();
        checks++;
        if (pc_out !== 16'h0051 || stack_unf !== 1'b1 || sp !== 3'd0) begin
            errors++;
            $display("FAIL unf: pc=%h unf=%b sp=%0d, required pc=0051 unf=1 sp=0",
                     pc_out, stack_unf, sp);
        end
        ra = 16'(pc_out + 1);
        set_in(0, 0, 0, 0, 1, 1, 0, 16'h0700);
        tick();
        set_in(0, 0, 0, 0, 1, 1, 1, 16'h0900);
        tick();
        checks++;
        if (pc_out !== ra || sp !== 3'd0) begin
            errors++;
            $display("FAIL call_ret: pc=%h sp=%0d, required pc=%h sp=0", pc_out, sp, ra);
        end
    endtask

    task automatic test_stall_reset();
        logic [15:0] hold;
        set_in(0, 0, 0, 0, 1, 1, 0, 16'h0A00);
        tick();
        set_in(0, 0, 0, 0, 1, 1, 0, 16'h0B00);
        tick();
        hold = pc_out;
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 1, 1, 1, 1, 0, 16'h0C00);
            #1;
            checks++;
            if (pc_next !== hold) begin
                errors++;
                $display("FAIL stall_next%0d: pc_next=%h, required %h", i, pc_next, hold);
            end
            tick();
            checks++;
            if (pc_out !== hold || sp !== 3'd2) begin
                errors++;
                $display("FAIL stall%0d: pc=%h sp=%0d, required pc=%h sp=2", i, pc_out, sp, hold);
            end
        end
        set_in(1, 0, 0, 0, 1, 1, 0, 16'h0D00);
        #1;
        checks++;
        if (pc_next !== RV) begin
            errors++;
            $display("FAIL rst_next: pc_next=%h, required %h", pc_next, RV);
        end
        tick();
        checks++;
        if (pc_out !== RV || sp !== 3'd0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
            errors++;
            $display("FAIL rst_call: pc=%h sp=%0d ovf=%b unf=%b, required pc=%h sp=0 flags 0",
                     pc_out, sp, stack_ovf, stack_unf, RV);
        end
    endtask

    task automatic test_random();
        logic [15:0] t;
        for (int n = 0; n < 400; n++) begin
            t = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 7) - 4);
            set_in($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 4) == 0, t);
            #1;
            checks++;
            if (pc_next !== exp_next()) begin
                errors++;
                $display("FAIL rnd_next%0d: pc_next=%h, required %h", n, pc_next, exp_next());
            end
            tick();
            checks++;
            if (pc_out !== m_pc || sp !== 3'(m_stack.size()) ||
                stack_ovf !== m_ovf || stack_unf !== m_unf) begin
                errors++;
                $display("FAIL rnd%0d: pc=%h sp=%0d ovf=%b unf=%b, required pc=%h sp=%0d ovf=%b unf=%b",
                         n, pc_out, sp, stack_ovf, stack_unf,
                         m_pc, m_stack.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        m_pc  = RV;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #2;
        test_reset();
        test_branches();
        test_call_ret();
        test_overflow();
        test_underflow_collision();
        test_stall_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
